// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg
// Purpose : shared constants and the response-tracking record used by the
//           two-port RAM arbiter (ram_s2p_arbiter) and its round-robin
//           sub-arbiter (rr_arbiter).
// Contents:
//   DEF_WORD_WIDTH / DEF_WORD_COUNT / DEF_NUM_REQ : default build geometry
//   MAX_NUM_REQ / IDX_WIDTH                       : widest requester index
//   MAX_WORD_WIDTH                                : widest forwardable word
//   rsp_trk_t                                     : one-cycle read tracking
//                                                   (valid, grant index,
//                                                   bypass flag, bypass data)
package ram_arb_pkg;

    localparam int DEF_WORD_WIDTH = 8;
    localparam int DEF_WORD_COUNT = 256;
    localparam int DEF_NUM_REQ    = 4;

    localparam int MAX_NUM_REQ    = 16;
    localparam int IDX_WIDTH      = 4;
    localparam int MAX_WORD_WIDTH = 64;

    // Sized for the largest legal configuration so the record can live in
    // the package; narrower builds simply use the low bits.
    typedef struct packed {
        logic                      valid;
        logic [IDX_WIDTH-1:0]      idx;
        logic                      byp;
        logic [MAX_WORD_WIDTH-1:0] data;
    } rsp_trk_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Purpose : round-robin arbiter with an internal priority pointer. The
//           search starts at the pointer and wraps modulo N; the first
//           active request wins. After a grant to g the pointer moves to
//           (g+1) mod N, otherwise it holds.
// Ports:
//   clk_i   in  1        clock
//   rstn_i  in  1        async active-low reset (pointer -> 0)
//   req_i   in  N        request vector
//   gnt_o   out N        one-hot grant, or zero
//   gidx_o  out PW       index of the granted requester (0 when none)
//   any_o   out 1        a grant is being issued this cycle
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic [N-1:0]  req_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] gidx_o,
    output logic          any_o
);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] cand;

    // Priority search from the pointer upward with wrap-around.
    always_comb begin
        gnt_o  = '0;
        gidx_o = '0;
        any_o  = 1'b0;
        cand   = '0;
        for (int i = 0; i < N; i++) begin
            cand = PW'((int'(ptr_q) + i) % N);
            if (!any_o && req_i[cand]) begin
                any_o  = 1'b1;
                gidx_o = cand;
            end
        end
        if (any_o) begin
            gnt_o[gidx_o] = 1'b1;
        end
    end

    // Pointer advances past the winner; explicit wrap keeps non-power-of-two N legal.
    always_comb begin
        ptr_d = ptr_q;
        if (any_o) begin
            ptr_d = (int'(gidx_o) == N - 1) ? '0 : gidx_o + PW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ram_s2p_arbiter.sv
// ram_s2p_arbiter
// Purpose : shares one simple-dual-port RAM (one write port, one read port
//           with 1-cycle read latency) between NUM_REQ requesters. Writes
//           and reads are arbitrated independently by two round-robin
//           arbiters; read responses come back one cycle after acceptance
//           on a one-hot strobe with shared data.
// Optional feature (macro RAM_S2P_ARBITER_BYPASS_EN):
//   when defined, a read accepted together with a write to the same address
//   returns the new write data (registered compare + forwarded data).
//   When undefined, no forwarding exists and such a read returns the old
//   RAM contents.
// Ports:
//   clk_i, rstn_i          clock, async active-low reset
//   wr_valid_i/wr_ready_o  per-requester write handshake (ready one-hot/zero)
//   wr_addr_i/wr_data_i    packed per-requester write address/data
//   rd_valid_i/rd_ready_o  per-requester read handshake (ready one-hot/zero)
//   rd_addr_i              packed per-requester read address
//   rsp_valid_o/rsp_data_o one-hot response strobe, shared response data
//   ram_we_o/ram_waddr_o/ram_wdata_o  RAM write port
//   ram_raddr_o/ram_rdata_i           RAM read port (data one cycle later)
import ram_arb_pkg::*;

module ram_s2p_arbiter #(
    parameter  int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter  int WORD_COUNT = DEF_WORD_COUNT,
    parameter  int NUM_REQ    = DEF_NUM_REQ,
    localparam int ADDR_WIDTH = $clog2(WORD_COUNT),
    localparam int IW         = $clog2(NUM_REQ)
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic [NUM_REQ-1:0]            wr_valid_i,
    output logic [NUM_REQ-1:0]            wr_ready_o,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [NUM_REQ*WORD_WIDTH-1:0] wr_data_i,
    input  logic [NUM_REQ-1:0]            rd_valid_i,
    output logic [NUM_REQ-1:0]            rd_ready_o,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] rd_addr_i,
    output logic [NUM_REQ-1:0]            rsp_valid_o,
    output logic [WORD_WIDTH-1:0]         rsp_data_o,
    output logic                          ram_we_o,
    output logic [ADDR_WIDTH-1:0]         ram_waddr_o,
    output logic [WORD_WIDTH-1:0]         ram_wdata_o,
    output logic [ADDR_WIDTH-1:0]         ram_raddr_o,
    input  logic [WORD_WIDTH-1:0]         ram_rdata_i
);

    logic [NUM_REQ-1:0] wr_req;
    logic [NUM_REQ-1:0] rd_req;
    logic [NUM_REQ-1:0] wr_gnt;
    logic [NUM_REQ-1:0] rd_gnt;
    logic [IW-1:0]      wr_gidx;
    logic [IW-1:0]      rd_gidx;
    logic               wr_any;
    logic               rd_any;
    rsp_trk_t           trk_q;
    rsp_trk_t           trk_d;
    logic               unused_trk;

    // Requests are masked while reset is held so no ready can rise then.
    assign wr_req = wr_valid_i & {NUM_REQ{rstn_i}};
    assign rd_req = rd_valid_i & {NUM_REQ{rstn_i}};

    rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .req_i  (wr_req),
        .gnt_o  (wr_gnt),
        .gidx_o (wr_gidx),
        .any_o  (wr_any)
    );

    rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .req_i  (rd_req),
        .gnt_o  (rd_gnt),
        .gidx_o (rd_gidx),
        .any_o  (rd_any)
    );

    assign wr_ready_o = wr_gnt;
    assign rd_ready_o = rd_gnt;

    // RAM port muxing: granted requester's fields, zero when idle.
    assign ram_we_o    = wr_any;
    assign ram_waddr_o = wr_any ? wr_addr_i[wr_gidx*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign ram_wdata_o = wr_any ? wr_data_i[wr_gidx*WORD_WIDTH +: WORD_WIDTH] : '0;
    assign ram_raddr_o = rd_any ? rd_addr_i[rd_gidx*ADDR_WIDTH +: ADDR_WIDTH] : '0;

    // Capture who was granted a read this cycle; the RAM answers next cycle.
    always_comb begin
        trk_d       = '0;
        trk_d.valid = rd_any;
        trk_d.idx   = IDX_WIDTH'(rd_gidx);
`ifdef RAM_S2P_ARBITER_BYPASS_EN
        trk_d.byp   = rd_any && wr_any && (ram_waddr_o == ram_raddr_o);
        trk_d.data  = MAX_WORD_WIDTH'(ram_wdata_o);
`endif
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            trk_q <= '0;
        end else begin
            trk_q <= trk_d;
        end
    end

    assign rsp_valid_o = trk_q.valid ? (NUM_REQ'(1) << trk_q.idx) : '0;

`ifdef RAM_S2P_ARBITER_BYPASS_EN
    assign rsp_data_o = !trk_q.valid ? '0 :
                        trk_q.byp    ? trk_q.data[WORD_WIDTH-1:0] : ram_rdata_i;
`else
    assign rsp_data_o = trk_q.valid ? ram_rdata_i : '0;
`endif

    // Bits of the shared record that a given build does not consume.
    assign unused_trk = ^{trk_q.byp, trk_q.data};

endmodule
